// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ID-stage control unit.
// Holds the MIPS opcode encodings, ALU-op and memory-size codes, the FSM
// encoding and the packed control bundle carried from ID into EX.
package ctrl_pkg;

    // Opcode encodings (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LB    = 6'b100000;
    localparam logic [5:0] OPC_LH    = 6'b100001;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_LBU   = 6'b100100;
    localparam logic [5:0] OPC_LHU   = 6'b100101;
    localparam logic [5:0] OPC_LWU   = 6'b100111;
    localparam logic [5:0] OPC_SB    = 6'b101000;
    localparam logic [5:0] OPC_SH    = 6'b101001;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    // ALU-op codes
    localparam logic [1:0] ALU_LDST   = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_IMM    = 2'b11;

    // Memory access size codes
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Control FSM encoding
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Control bundle registered into the ID/EX boundary
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] mem_size;
        logic       mem_uns;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(14'h0000);

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational opcode -> control bundle decoder.
// Ports:
//   opcode   in  6   instr[31:26]
//   ctrl     out     decoded control bundle (all zero for unknown opcodes)
//   illegal  out 1   opcode is not in the decode table
//   reads_rt out 1   instruction uses rt as a source (R-type, store, branch)
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       reads_rt
);

    // Opcode decode table
    always_comb begin
        ctrl     = CTRL_NOP;
        illegal  = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
                reads_rt       = 1'b1;
            end
            OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU, OPC_LWU: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_LDST;
                // opcode[2] marks the unsigned loads; opcode[1:0] the size
                ctrl.mem_uns    = opcode[2];
                case (opcode[1:0])
                    2'b00:   ctrl.mem_size = MEM_BYTE;
                    2'b01:   ctrl.mem_size = MEM_HALF;
                    default: ctrl.mem_size = MEM_WORD;
                endcase
            end
            OPC_SB, OPC_SH, OPC_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_LDST;
                reads_rt       = 1'b1;
                case (opcode[1:0])
                    2'b00:   ctrl.mem_size = MEM_BYTE;
                    2'b01:   ctrl.mem_size = MEM_HALF;
                    default: ctrl.mem_size = MEM_WORD;
                endcase
            end
            OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SLTI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_IMM;
            end
            OPC_BEQ, OPC_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = opcode[0];
                ctrl.alu_op    = ALU_BRANCH;
                reads_rt       = 1'b1;
            end
            OPC_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// pipelined_ctrl_unit: ID-stage control for the MIPS pipeline.
// Decodes the IF/ID instruction, resolves flush / HALT / load-use / illegal
// priority and registers the control bundle into the ID/EX boundary.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_valid, i_opcode, i_funct, i_rs, i_rt, i_flush   ID-stage inputs
//   o_stall             combinational hold of PC and IF/ID
//   o_valid, o_* ctrl   registered EX control bundle
//   o_funct, o_rt_ex    registered funct and rt of the EX instruction
//   o_illegal           one-cycle pulse for an illegal opcode turned into a bubble
//   o_halted            FSM is in HALT
module pipelined_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int         REG_W       = 5,
    parameter int         ALUOP_W     = 2,
    parameter bit         LOAD_USE_EN = 1'b1,
    parameter logic [5:0] HALT_OPC    = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_funct,
    input  logic [REG_W-1:0]   i_rs,
    input  logic [REG_W-1:0]   i_rt,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_valid,
    output logic               o_reg_dst,
    output logic               o_branch,
    output logic               o_branch_ne,
    output logic               o_jump,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_alu_src,
    output logic               o_reg_write,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [1:0]         o_mem_size,
    output logic               o_mem_uns,
    output logic [5:0]         o_funct,
    output logic [REG_W-1:0]   o_rt_ex,
    output logic               o_illegal,
    output logic               o_halted
);

    ctrl_t              dec_ctrl_s;
    logic               dec_illegal_s;
    logic               dec_reads_rt_s;
    logic               hazard_s;
    logic               halt_opc_s;
    logic               stall_s;
    logic               issue_s;
    logic               illegal_pulse_s;
    state_t             next_state_s;

    state_t             state_r;
    ctrl_t              ex_r;
    logic               valid_r;
    logic [5:0]         funct_r;
    logic [REG_W-1:0]   rt_r;
    logic               illegal_r;

    ctrl_decode_comb u_decode (
        .opcode   (i_opcode),
        .ctrl     (dec_ctrl_s),
        .illegal  (dec_illegal_s),
        .reads_rt (dec_reads_rt_s)
    );

    // Load in EX whose destination is a source of the ID instruction
    always_comb begin
        hazard_s = LOAD_USE_EN && valid_r && ex_r.mem_read
                   && (rt_r != {REG_W{1'b0}})
                   && ((rt_r == i_rs) || ((rt_r == i_rt) && dec_reads_rt_s));
        halt_opc_s = (i_opcode == HALT_OPC);
    end

    // Per-cycle priority: HALT holds everything, then flush, empty slot,
    // hazard, HALT opcode, illegal opcode, normal issue
    always_comb begin
        stall_s         = 1'b0;
        issue_s         = 1'b0;
        illegal_pulse_s = 1'b0;
        next_state_s    = state_r;
        if (state_r == ST_HALT) begin
            stall_s      = 1'b1;
            next_state_s = ST_HALT;
        end else if (i_flush) begin
            issue_s = 1'b0;
        end else if (!i_valid) begin
            issue_s = 1'b0;
        end else if (hazard_s) begin
            stall_s = 1'b1;
        end else if (halt_opc_s) begin
            next_state_s = ST_HALT;
        end else if (dec_illegal_s) begin
            illegal_pulse_s = 1'b1;
        end else begin
            issue_s = 1'b1;
        end
    end

    // ID/EX boundary and FSM state; non-issue cycles load a full bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_RUN;
            ex_r      <= CTRL_NOP;
            valid_r   <= 1'b0;
            funct_r   <= 6'b000000;
            rt_r      <= {REG_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            ex_r      <= issue_s ? dec_ctrl_s : CTRL_NOP;
            valid_r   <= issue_s;
            funct_r   <= issue_s ? i_funct : 6'b000000;
            rt_r      <= issue_s ? i_rt : {REG_W{1'b0}};
            illegal_r <= illegal_pulse_s;
        end
    end

    assign o_stall      = stall_s;
    assign o_valid      = valid_r;
    assign o_reg_dst    = ex_r.reg_dst;
    assign o_branch     = ex_r.branch;
    assign o_branch_ne  = ex_r.branch_ne;
    assign o_jump       = ex_r.jump;
    assign o_mem_read   = ex_r.mem_read;
    assign o_mem_write  = ex_r.mem_write;
    assign o_mem_to_reg = ex_r.mem_to_reg;
    assign o_alu_src    = ex_r.alu_src;
    assign o_reg_write  = ex_r.reg_write;
    // Wider ALU-op fields zero-fill the reserved upper bits
    assign o_alu_op     = ALUOP_W'(ex_r.alu_op);
    assign o_mem_size   = ex_r.mem_size;
    assign o_mem_uns    = ex_r.mem_uns;
    assign o_funct      = funct_r;
    assign o_rt_ex      = rt_r;
    assign o_illegal    = illegal_r;
    assign o_halted     = (state_r == ST_HALT);

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Scoreboard bench for pipelined_ctrl_unit: the driver pushes the expected EX
// bundle for every instruction that should issue; a negedge monitor pops and
// compares whenever o_valid is high and checks bubbles are all-zero otherwise.
module tb_pipelined_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [5:0] i_opcode = 6'b000000;
    logic [5:0] i_funct = 6'b000000;
    logic [4:0] i_rs = 5'd0;
    logic [4:0] i_rt = 5'd0;
    logic       i_flush = 1'b0;
    logic       o_stall, o_valid, o_reg_dst, o_branch, o_branch_ne, o_jump;
    logic       o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_write;
    logic [1:0] o_alu_op, o_mem_size;
    logic       o_mem_uns;
    logic [5:0] o_funct;
    logic [4:0] o_rt_ex;
    logic       o_illegal, o_halted;

    int n_checks = 0;
    int n_fail = 0;
    int ill_seen = 0;
    int ill_exp = 0;
    logic [24:0] exp_q[$];
    logic [24:0] act_s;

    pipelined_ctrl_unit dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_opcode(i_opcode),
        .i_funct(i_funct), .i_rs(i_rs), .i_rt(i_rt), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_reg_dst(o_reg_dst),
        .o_branch(o_branch), .o_branch_ne(o_branch_ne), .o_jump(o_jump),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src),
        .o_reg_write(o_reg_write), .o_alu_op(o_alu_op), .o_mem_size(o_mem_size),
        .o_mem_uns(o_mem_uns), .o_funct(o_funct), .o_rt_ex(o_rt_ex),
        .o_illegal(o_illegal), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    assign act_s = {o_reg_dst, o_branch, o_branch_ne, o_jump, o_mem_read,
                    o_mem_write, o_mem_to_reg, o_alu_src, o_reg_write,
                    o_alu_op, o_mem_size, o_mem_uns, o_funct, o_rt_ex};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ctl = {reg_dst,branch,branch_ne,jump,mem_read,mem_write,mem_to_reg,alu_src,reg_write}
    task automatic expect_b(input logic [8:0] ctl, input logic [1:0] aop, input logic [1:0] sz,
                            input logic uns, input logic [5:0] fn, input logic [4:0] rt);
        exp_q.push_back({ctl, aop, sz, uns, fn, rt});
    endtask

    // Present one ID instruction for one cycle and check the stall it causes
    task automatic issue(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic fl,
                         input logic exp_stall);
        i_valid = v; i_opcode = opc; i_funct = fn; i_rs = rs; i_rt = rt; i_flush = fl;
        @(negedge clk);
        chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_flush = 1'b0;
    endtask

    // Monitor: compare issued bundles in order, bubbles must be all-zero
    always @(negedge clk) begin
        if (!reset) begin
            if (o_illegal) ill_seen++;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {7'd0, act_s}, 32'hFFFF_FFFF);
                end else begin
                    chk("bundle", {7'd0, act_s}, {7'd0, exp_q.pop_front()});
                end
            end else begin
                chk("bubble", {7'd0, act_s}, 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_ctrl", {7'd0, act_s}, 32'd0);
        chk("reset_halted", {31'd0, o_halted}, 32'd0);
        reset = 1'b0;

        // 1: ADDI
        expect_b(9'b000000011, 2'b11, 2'b00, 1'b0, 6'd0, 5'd2);
        issue(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2, 1'b0, 1'b0);
        // 2: LW rt=5 then ADD rs=5 stalls once, then issues
        expect_b(9'b000010111, 2'b00, 2'b10, 1'b0, 6'd0, 5'd5);
        issue(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        issue(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd6, 1'b0, 1'b1);
        expect_b(9'b100000001, 2'b10, 2'b00, 1'b0, 6'b100000, 5'd6);
        issue(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd6, 1'b0, 1'b0);
        // LW rt=0 then ADD rs=0: no stall
        expect_b(9'b000010111, 2'b00, 2'b10, 1'b0, 6'd0, 5'd0);
        issue(1'b1, 6'b100011, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_b(9'b100000001, 2'b10, 2'b00, 1'b0, 6'b100000, 5'd0);
        issue(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 1'b0, 1'b0);
        // 3: LW rt=5 then SW rt=5 stalls
        expect_b(9'b000010111, 2'b00, 2'b10, 1'b0, 6'd0, 5'd5);
        issue(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        issue(1'b1, 6'b101011, 6'd0, 5'd1, 5'd5, 1'b0, 1'b1);
        expect_b(9'b000001010, 2'b00, 2'b10, 1'b0, 6'd0, 5'd5);
        issue(1'b1, 6'b101011, 6'd0, 5'd1, 5'd5, 1'b0, 1'b0);
        // LW rt=5 then ADDI rt=5 rs=3: rt is a destination, no stall
        expect_b(9'b000010111, 2'b00, 2'b10, 1'b0, 6'd0, 5'd5);
        issue(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        expect_b(9'b000000011, 2'b11, 2'b00, 1'b0, 6'd0, 5'd5);
        issue(1'b1, 6'b001000, 6'd0, 5'd3, 5'd5, 1'b0, 1'b0);
        // 4: flush beats hazard; flushed BNE is a bubble; BNE alone decodes
        expect_b(9'b000010111, 2'b00, 2'b10, 1'b0, 6'd0, 5'd5);
        issue(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        issue(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd6, 1'b1, 1'b0);
        issue(1'b1, 6'b000101, 6'd0, 5'd1, 5'd2, 1'b1, 1'b0);
        expect_b(9'b011000000, 2'b01, 2'b00, 1'b0, 6'd0, 5'd2);
        issue(1'b1, 6'b000101, 6'd0, 5'd1, 5'd2, 1'b0, 1'b0);
        expect_b(9'b000100000, 2'b00, 2'b00, 1'b0, 6'd0, 5'd0);
        issue(1'b1, 6'b000010, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // 5: illegal opcode pulses once, next instruction decodes normally
        ill_exp++;
        issue(1'b1, 6'b010011, 6'd0, 5'd1, 5'd2, 1'b0, 1'b0);
        chk("illegal_pulse", {31'd0, o_illegal}, 32'd1);
        expect_b(9'b000000011, 2'b11, 2'b00, 1'b0, 6'd0, 5'd4);
        issue(1'b1, 6'b001000, 6'd0, 5'd1, 5'd4, 1'b0, 1'b0);
        chk("illegal_clear", {31'd0, o_illegal}, 32'd0);
        // empty IF/ID slot: bubble, no stall
        issue(1'b0, 6'b100011, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        // LHU
        expect_b(9'b000010111, 2'b00, 2'b01, 1'b1, 6'd0, 5'd7);
        issue(1'b1, 6'b100101, 6'd0, 5'd1, 5'd7, 1'b0, 1'b0);
        // 6: HALT, stall held, flush ignored
        issue(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("halted", {31'd0, o_halted}, 32'd1);
        issue(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2, 1'b0, 1'b1);
        issue(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        chk("halted_after_flush", {31'd0, o_halted}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ctrl", {7'd0, act_s}, 32'd0);
        reset = 1'b0;
        expect_b(9'b000010111, 2'b00, 2'b01, 1'b1, 6'd0, 5'd9);
        issue(1'b1, 6'b100101, 6'd0, 5'd2, 5'd9, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("illegal_count", ill_seen, ill_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
